digest_byte_serializer: RTL and testbench

- Downstream stage of the 128-bit digest lane-reversal converter.
- Accepts one big-endian digest word via valid/ready and streams it out one byte per handshake, most significant byte first.
- Feeds the byte-wide host/UART transmit path of the SHAKE256 core.
- The block is stateful. It buffers one digest and applies backpressure upstream while a stream is in flight.

---
 rtl/digest_byte_serializer.sv | 137 +++++++++++++
 tb/tb_digest_byte_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/digest_byte_serializer.sv
// digest_byte_serializer
// Buffers one big-endian digest word and streams it out most significant
// byte first, one item per out_valid/out_ready handshake.
// Optional build macro DIGEST_HEX_ASCII_EN: each byte is emitted as two
// lowercase ASCII hex characters, high nibble first.
module digest_byte_serializer #(
  parameter int DIGEST_W = 128,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGEST_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int N = DIGEST_W / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int ITEMS = 2 * N;
`else
  localparam int ITEMS = N;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITEMS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIGEST_W-1:0] r_shreg;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                w_capture;
  logic                w_fire;
  logic                w_last;
  logic [7:0]          w_top;
  logic [7:0]          w_item;

`ifdef DIGEST_HEX_ASCII_EN
  logic                r_nib;
  logic [3:0]          w_nibble;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
`endif

  assign w_top = r_shreg[DIGEST_W-1 -: 8];

  // Item presented on the output: raw top byte or its current hex character
`ifdef DIGEST_HEX_ASCII_EN
  always_comb begin
    w_nibble = r_nib ? w_top[3:0] : w_top[7:4];
    w_item   = hex_char(w_nibble);
  end
`else
  always_comb begin
    w_item = w_top;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake qualification
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_fire    = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_capture = 1'b1;
          w_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          w_fire = 1'b1;
          if (r_count == LAST) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift register, item counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
`ifdef DIGEST_HEX_ASCII_EN
      r_nib   <= 1'b0;
`endif
    end else begin
      r_done <= w_last;
      if (w_capture) begin
        r_shreg <= in_data;
        r_count <= '0;
`ifdef DIGEST_HEX_ASCII_EN
        r_nib   <= 1'b0;
`endif
      end else if (w_fire) begin
        r_count <= r_count + CNT_W'(1);
`ifdef DIGEST_HEX_ASCII_EN
        // Advance to the next byte only once its low-nibble char is taken
        r_nib <= ~r_nib;
        if (r_nib) r_shreg <= r_shreg << 8;
`else
        r_shreg <= r_shreg << 8;
`endif
      end
    end
  end

  // Outputs are decoded from registered state only; out_data idles at zero
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state == S_SEND);
    out_valid = (r_state == S_SEND);
    out_data  = (r_state == S_SEND) ? w_item : 8'h00;
    done      = r_done;
  end

endmodule

// File: tb/tb_digest_byte_serializer.sv
// Self-checking bench for digest_byte_serializer (raw or hex build).
module tb_digest_byte_serializer;

  localparam int DW = 128;
  localparam int N  = DW / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int ITEMS = 2 * N;
`else
  localparam int ITEMS = N;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;

  digest_byte_serializer #(.DIGEST_W(DW), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            mode;
    logic [7:0]    first_raw;
    logic [7:0]    first_hex;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: k-th output item of a digest, from byte/nibble arithmetic
  function automatic logic [7:0] model_item(input logic [DW-1:0] d, input int k);
    int b;
    logic [7:0] byte_v;
    logic [3:0] nib;
`ifdef DIGEST_HEX_ASCII_EN
    b = k / 2;
`else
    b = k;
`endif
    byte_v = 8'((d >> (8 * (N - 1 - b))) & 128'hFF);
`ifdef DIGEST_HEX_ASCII_EN
    nib = (k % 2 == 0) ? byte_v[7:4] : byte_v[3:0];
    return (nib < 10) ? (8'h30 + 8'(nib)) : (8'h61 + 8'(nib) - 8'd10);
`else
    nib = 4'h0;
    return byte_v + 8'(nib);
`endif
  endfunction

  function automatic logic [11:0] obs();
    return {out_valid, busy, in_ready, done, out_data};
  endfunction

  // Present a digest in IDLE; returns at the first cycle it should be streaming
  task automatic start(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume and check one stream; optionally chain a second digest with in_valid
  // held through the done cycle, or stop early after stop_after handshakes.
  task automatic stream(input logic [DW-1:0] d, input int mode, input bit chain,
                        input logic [DW-1:0] nd, input int stop_after);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < ITEMS && cyc <= 4 * ITEMS + 20) begin
      chk($sformatf("item%0d", k), 32'(obs()), {20'h0, 4'b1100, model_item(d, k)});
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      if (k < ITEMS - 1) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = chain;
        in_data  = chain ? nd : in_data;
      end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        k++;
        if (stop_after > 0 && k == stop_after) return;
      end
    end
    if (k < ITEMS) begin
      chk("stream_timeout", 32'(k), 32'(ITEMS));
      return;
    end
    chk("done_cycle", 32'(obs()), {20'h0, 4'b0011, 8'h00});
    @(negedge clk);
    if (chain) in_valid = 1'b0;
    else chk("idle_after", 32'(obs()), {20'h0, 4'b0010, 8'h00});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    logic [DW-1:0] d;
    tbl[0] = '{128'h00112233445566778899AABBCCDDEEFF, 0, 8'h00, 8'h30};
    tbl[1] = '{128'h00112233445566778899AABBCCDDEEFF, 1, 8'h00, 8'h30};
    tbl[2] = '{128'hA5C3_0000_1234_5678_9ABC_DEF0_0000_0001, 2, 8'hA5, 8'h61};
    tbl[3] = '{128'h0FFF_EEDD_0102_0304_F0E1_D2C3_B4A5_9687, 2, 8'h0F, 8'h30};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(obs()), {20'h0, 4'b0010, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(obs()), {20'h0, 4'b0010, 8'h00});

    for (int i = 0; i < 4; i++) begin
      start(tbl[i].data);
`ifdef DIGEST_HEX_ASCII_EN
      chk($sformatf("first_item_v%0d", i), {23'h0, out_valid, out_data}, {23'h0, 1'b1, tbl[i].first_hex});
`else
      chk($sformatf("first_item_v%0d", i), {23'h0, out_valid, out_data}, {23'h0, 1'b1, tbl[i].first_raw});
`endif
      stream(tbl[i].data, tbl[i].mode, 1'b0, '0, 0);
    end

    // Back-to-back: second digest captured in the done cycle
    start(128'h00112233445566778899AABBCCDDEEFF);
    stream(128'h00112233445566778899AABBCCDDEEFF, 0, 1'b1, 128'hFFEEDDCCBBAA99887766554433221100, 0);
    stream(128'hFFEEDDCCBBAA99887766554433221100, 0, 1'b0, '0, 0);

    // Reset after the 5th handshake: immediate return to idle, no done
    start(128'h0123456789ABCDEF0123456789ABCDEF);
    stream(128'h0123456789ABCDEF0123456789ABCDEF, 0, 1'b0, '0, 5);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("reset_midstream", 32'(obs()), {20'h0, 4'b0010, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_reset", 32'(obs()), {20'h0, 4'b0010, 8'h00});
    start(128'hDEADBEEF00112233445566778899AABB);
    stream(128'hDEADBEEF00112233445566778899AABB, 1, 1'b0, '0, 0);

    // Randomized digests under random backpressure
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      start(d);
      stream(d, 2, 1'b0, '0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
